bin_to_digit_codes: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3) that produces the per-digit
//   5-bit display codes consumed by the eight-digit seven-segment driver.

---
 rtl/bin_to_digit_codes_pkg.sv | 17 +
 rtl/bin_to_digit_codes_add3.sv | 9 +
 rtl/bin_to_digit_codes.sv | 144 ++++++++++++++
 tb/tb_bin_to_digit_codes.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bin_to_digit_codes_pkg.sv
// Shared definitions for the binary-to-display-code converter and the seven-segment driver:
// FSM encoding, display codes and accumulator sizing.
package bin_to_digit_codes_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FORMAT = 2'd2;

  localparam logic [4:0] CODE_BLANK = 5'h1F;
  localparam logic [4:0] CODE_DASH  = 5'h10;

  // Decimal digit count of 2^width-1, i.e. floor(width*log10(2))+1 (2^width is never a power of ten).
  function automatic int acc_nibbles(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin_to_digit_codes_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3_nibble (
  input  logic [3:0] n_i,
  output logic [3:0] n_o
);

  assign n_o = (n_i >= 4'd5) ? (n_i + 4'd3) : n_i;

endmodule

// File: rtl/bin_to_digit_codes.sv
// Sequential shift-and-add-3 binary-to-BCD converter producing per-digit display codes,
// with leading-zero blanking and an overflow dash pattern.
module bin_to_digit_codes
  import bin_to_digit_codes_pkg::*;
#(
  parameter int         WIDTH    = 27,
  parameter int         DIGITS   = 8,
  parameter logic [4:0] BLANK    = CODE_BLANK,
  parameter int         LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  done,
  output logic                  ovf,
  output logic [5*DIGITS-1:0]   digits
);

  localparam int NIB  = acc_nibbles(WIDTH);
  localparam int BCDW = 4 * NIB;
  localparam int EXTW = 4 * ((NIB > DIGITS) ? NIB : DIGITS);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [BCDW-1:0]      bcd_q, bcd_d;
  logic [BCDW-1:0]      adj_s;
  logic [EXTW-1:0]      bcd_ext_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [5*DIGITS-1:0]  digits_q, digits_d, fmt_s;
  logic                 ovf_q, ovf_d, ovf_s;
  logic                 done_q, done_d;

  for (genvar g = 0; g < NIB; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .n_i (bcd_q[4*g +: 4]),
      .n_o (adj_s[4*g +: 4])
    );
  end

  assign bcd_ext_s = EXTW'(bcd_q);

  if (NIB > DIGITS) begin : g_ovf
    assign ovf_s = |bcd_ext_s[EXTW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign ovf_s = 1'b0;
  end

  // Display codes from the finished accumulator; scanned from the top so blanking stops at the first non-zero digit.
  always_comb begin : fmt_comb
    logic       seen;
    logic [3:0] nib;
    seen  = 1'b0;
    nib   = 4'd0;
    fmt_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_ext_s[4*i +: 4];
      if (ovf_s) begin
        fmt_s[5*i +: 5] = CODE_DASH;
      end else if ((LZ_BLANK != 0) && !seen && (nib == 4'd0) && (i != 0)) begin
        fmt_s[5*i +: 5] = BLANK;
      end else begin
        fmt_s[5*i +: 5] = {1'b0, nib};
      end
      if (nib != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
    end
  end

  // Next-state logic for the FSM, shift register, iteration counter and output registers.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj_s[BCDW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FORMAT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FORMAT: begin
        digits_d = fmt_s;
        ovf_d    = ovf_s;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= {DIGITS{BLANK}};
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;

endmodule

// File: tb/tb_bin_to_digit_codes.sv
// Self-checking bench for bin_to_digit_codes: directed corner cases plus random values
// compared against a decimal reference model.
module tb_bin_to_digit_codes;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [26:0] bin_in = '0;
  logic        ready, done, ovf;
  logic [39:0] digits;

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] exp_hold;

  localparam logic [39:0] ALL_BLANK = {8{5'h1F}};

  bin_to_digit_codes dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .ready  (ready),
    .done   (done),
    .ovf    (ovf),
    .digits (digits)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digit codes from repeated division by ten.
  function automatic logic [39:0] ref_digits(input int unsigned v);
    logic [39:0] r;
    int d[8];
    int top;
    int unsigned t;
    r = '0;
    t = v;
    top = 0;
    if (v >= 32'd100000000) begin
      for (int i = 0; i < 8; i++) r[5*i +: 5] = 5'h10;
      return r;
    end
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(t % 10);
      t = t / 10;
    end
    for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 8; i++) r[5*i +: 5] = (i > top) ? 5'h1F : 5'(d[i]);
    return r;
  endfunction

  // Waits (bounded) for done; optionally pokes start mid-conversion and checks the outputs hold.
  task automatic wait_done(input bit interfere, output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (interfere && k == 5) begin
        start  = 1'b1;
        bin_in = 27'd4444;
      end
      if (interfere && k == 6) start = 1'b0;
      if (k == 10 && done !== 1'b1) check_val("hold", 64'(digits), 64'(exp_hold));
    end while (done !== 1'b1 && k < 100);
  endtask

  task automatic run_conv(input int unsigned v, input bit interfere);
    int k;
    logic [39:0] exp_d;
    exp_d = ref_digits(v);
    @(negedge clk);
    bin_in = v[26:0];
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 27'($urandom);
    wait_done(interfere, k);
    check_val("latency", 64'(k), 64'd28);
    check_val("digits", 64'(digits), 64'(exp_d));
    check_val("ovf", 64'(ovf), 64'(v >= 32'd100000000));
    check_val("ready_at_done", 64'(ready), 64'd1);
    @(posedge clk); #1;
    check_val("done_pulse", 64'(done), 64'd0);
    exp_hold = exp_d;
  endtask

  initial begin
    int k;
    int n_done;
    exp_hold = ALL_BLANK;

    #12;
    check_val("rst_ready", 64'(ready), 64'd1);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_ovf", 64'(ovf), 64'd0);
    check_val("rst_digits", 64'(digits), 64'(ALL_BLANK));
    @(negedge clk);
    rst = 1'b1;

    run_conv(12345678, 1'b0);
    check_val("d12345678", 64'(digits),
              64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
    run_conv(0, 1'b0);
    check_val("zero", 64'(digits), 64'({{7{5'h1F}}, 5'd0}));
    run_conv(907, 1'b0);
    check_val("d907", 64'(digits), 64'({{5{5'h1F}}, 5'd9, 5'd0, 5'd7}));
    run_conv(99999999, 1'b0);
    run_conv(100000000, 1'b0);
    run_conv(134217727, 1'b0);
    run_conv(10000000, 1'b0);

    run_conv(86420, 1'b1);

    // start held high across two conversions
    exp_hold = ref_digits(86420);
    @(negedge clk);
    bin_in = 27'd55555;
    start  = 1'b1;
    @(posedge clk); #1;
    bin_in = 27'd123;
    wait_done(1'b0, k);
    check_val("b2b_lat1", 64'(k), 64'd28);
    check_val("b2b_dig1", 64'(digits), 64'(ref_digits(55555)));
    exp_hold = ref_digits(55555);
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 27'd999;
    wait_done(1'b0, k);
    check_val("b2b_gap", 64'(k + 1), 64'd29);
    check_val("b2b_dig2", 64'(digits), 64'(ref_digits(123)));
    exp_hold = ref_digits(123);

    // reset ten cycles into a conversion
    @(negedge clk);
    bin_in = 27'd7654321;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_ready", 64'(ready), 64'd1);
    check_val("mid_rst_done", 64'(done), 64'd0);
    check_val("mid_rst_ovf", 64'(ovf), 64'd0);
    check_val("mid_rst_digits", 64'(digits), 64'(ALL_BLANK));
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    check_val("no_done_after_rst", 64'(n_done), 64'd0);
    check_val("blank_after_rst", 64'(digits), 64'(ALL_BLANK));
    exp_hold = ALL_BLANK;
    run_conv(4321, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_conv($urandom_range(134217727, 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
